// File: rtl/ca_pkg.sv
// ============================================================================
//  Module      : ca_pkg
//  Description : Shared constants and types for the 1-D cellular-automaton
//                row generator: screen geometry, FSM state encoding and the
//                seed LFSR definition.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ca_pkg;

    // Default screen geometry (one cell per pixel, 1-bit frame buffer)
    localparam int WIDTH    = 640;
    localparam int HEIGHT   = 480;
    localparam int CENTER   = WIDTH / 2;
    localparam int FB_DEPTH = WIDTH * HEIGHT;

    // Generator FSM states
    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_SEED  = 3'd1,
        S_IDLE  = 3'd2,
        S_GEN   = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    // Random-seed LFSR: shift left, feedback into bit 0
    localparam logic [31:0] LFSR_RESET = 32'h0000_0001;
    localparam int          LFSR_TAP_A = 31;
    localparam int          LFSR_TAP_B = 21;
    localparam int          LFSR_TAP_C = 1;
    localparam int          LFSR_TAP_D = 0;

endpackage : ca_pkg

`default_nettype wire

// File: rtl/ca_rule_row.sv
// ============================================================================
//  Module      : ca_rule_row
//  Description : Combinational next-generation computation for a full row of
//                an elementary (Wolfram) cellular automaton. Neighbourhoods
//                wrap around the row ends (toroidal).
//  Ports       : i_cur_gen  - current generation, bit x = column x
//                i_rule     - 8-bit Wolfram rule number
//                o_next_gen - next generation, bit x = column x
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ca_rule_row #(
    parameter int WIDTH = 640
) (
    input  logic [WIDTH-1:0] i_cur_gen,
    input  logic [7:0]       i_rule,
    output logic [WIDTH-1:0] o_next_gen
);

    for (genvar x = 0; x < WIDTH; x++) begin : g_cell
        localparam int c_left  = (x == 0)         ? WIDTH - 1 : x - 1;
        localparam int c_right = (x == WIDTH - 1) ? 0         : x + 1;

        // Left neighbour is the MSB of the rule index
        assign o_next_gen[x] = i_rule[{i_cur_gen[c_left], i_cur_gen[x], i_cur_gen[c_right]}];
    end : g_cell

endmodule : ca_rule_row

`default_nettype wire

// File: rtl/ca_row_generator.sv
// ============================================================================
//  Module      : ca_row_generator
//  Description : 1-D cellular-automaton engine driving port A of a 1-bit
//                frame buffer. Clears the buffer, writes a seed row, then on
//                each request computes the next generation and streams it,
//                one pixel per cycle, into the next screen row.
//  Ports       : clk, reset     - clock, synchronous active-high reset
//                rule           - Wolfram rule, used in the compute cycle
//                seed_mode      - 0 centre cell, 1 LFSR random row
//                step           - rising edge requests one generation
//                run            - level, request whenever idle
//                restart        - pulse, abort and re-clear
//                mem_addr/data/we - frame-buffer port A write port
//                busy           - low only when idle
//                row            - screen row of last written generation
//                gen_count      - generations since last clear
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ca_row_generator #(
    parameter int WIDTH  = ca_pkg::WIDTH,
    parameter int HEIGHT = ca_pkg::HEIGHT,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rule,
    input  logic              seed_mode,
    input  logic              step,
    input  logic              run,
    input  logic              restart,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic [8:0]        row,
    output logic [15:0]       gen_count
);

    import ca_pkg::*;

    localparam int                c_col_w     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int                c_center    = WIDTH / 2;
    localparam int                c_fb_depth  = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(c_fb_depth - 1);
    localparam logic [ADDR_W-1:0] c_last_base = ADDR_W'(c_fb_depth - WIDTH);
    localparam logic [ADDR_W-1:0] c_width_a   = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] c_last_col  = ADDR_W'(WIDTH - 1);
    localparam logic [8:0]        c_last_row  = 9'(HEIGHT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;        // clear address / column counter
    logic [ADDR_W-1:0]   r_row_base;
    logic [WIDTH-1:0]    r_cur_gen;
    logic [31:0]         r_lfsr;
    logic                r_step_prev;
    logic                r_seed_mode;

    logic [WIDTH-1:0]    w_next_gen;
    logic                w_request;
    logic [c_col_w-1:0]  w_col;
    logic [c_col_w-1:0]  w_col_nxt;
    logic                w_seed_bit;
    logic                w_lfsr_fb;
    logic [ADDR_W-1:0]   w_base_nxt;

    ca_rule_row #(
        .WIDTH (WIDTH)
    ) u_rule_row (
        .i_cur_gen  (r_cur_gen),
        .i_rule     (rule),
        .o_next_gen (w_next_gen)
    );

    assign w_request  = (step & ~r_step_prev) | run;
    assign w_col      = r_cnt[c_col_w-1:0];
    assign w_col_nxt  = w_col + c_col_w'(1);
    assign w_lfsr_fb  = r_lfsr[LFSR_TAP_A] ^ r_lfsr[LFSR_TAP_B] ^
                        r_lfsr[LFSR_TAP_C] ^ r_lfsr[LFSR_TAP_D];
    assign w_seed_bit = r_seed_mode ? r_lfsr[0] : (w_col == c_col_w'(c_center));
    // Row base advances by add/wrap rather than row*WIDTH
    assign w_base_nxt = (r_row_base == c_last_base) ? '0 : r_row_base + c_width_a;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (restart) begin
            w_state_nxt = S_CLEAR;
        end else begin
            case (r_state)
                S_CLEAR: if (r_cnt == c_last_addr) w_state_nxt = S_SEED;
                S_SEED:  if (r_cnt == c_last_col)  w_state_nxt = S_IDLE;
                S_IDLE:  if (w_request)            w_state_nxt = S_GEN;
                S_GEN:                             w_state_nxt = S_WRITE;
                S_WRITE: if (r_cnt == c_last_col)  w_state_nxt = S_IDLE;
                default:                           w_state_nxt = S_CLEAR;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath and registered write port. In CLEAR/SEED the write for
    // r_cnt is issued one cycle after the state sees it; in GEN/WRITE the
    // outputs are prepared one cycle ahead so the first pixel lands in the
    // first WRITE cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr    <= '0;
            mem_data    <= 1'b0;
            mem_we      <= 1'b0;
            busy        <= 1'b1;
            row         <= '0;
            gen_count   <= '0;
            r_cnt       <= '0;
            r_row_base  <= '0;
            r_cur_gen   <= '0;
            r_lfsr      <= LFSR_RESET;
            r_step_prev <= 1'b0;
            r_seed_mode <= 1'b0;
        end else begin
            // Edge detector keeps tracking while busy so a held level never retriggers
            r_step_prev <= step;

            if (restart) begin
                // Present the first clear write immediately
                mem_we     <= 1'b1;
                mem_addr   <= '0;
                mem_data   <= 1'b0;
                busy       <= 1'b1;
                r_cnt      <= ADDR_W'(1);
                row        <= '0;
                gen_count  <= '0;
                r_row_base <= '0;
                r_lfsr     <= LFSR_RESET;
            end else begin
                case (r_state)
                    S_CLEAR: begin
                        mem_we   <= 1'b1;
                        mem_addr <= r_cnt;
                        mem_data <= 1'b0;
                        busy     <= 1'b1;
                        if (r_cnt == c_last_addr) begin
                            r_cnt       <= '0;
                            r_seed_mode <= seed_mode;
                        end else begin
                            r_cnt <= r_cnt + ADDR_W'(1);
                        end
                    end

                    S_SEED: begin
                        mem_we           <= 1'b1;
                        mem_addr         <= r_cnt;
                        mem_data         <= w_seed_bit;
                        busy             <= 1'b1;
                        r_cur_gen[w_col] <= w_seed_bit;
                        if (r_seed_mode) begin
                            r_lfsr <= {r_lfsr[30:0], w_lfsr_fb};
                        end
                        if (r_cnt == c_last_col) begin
                            r_cnt      <= '0;
                            row        <= '0;
                            gen_count  <= '0;
                            r_row_base <= '0;
                        end else begin
                            r_cnt <= r_cnt + ADDR_W'(1);
                        end
                    end

                    S_IDLE: begin
                        mem_we <= 1'b0;
                        busy   <= w_request;
                    end

                    S_GEN: begin
                        r_cur_gen  <= w_next_gen;
                        row        <= (row == c_last_row) ? '0 : row + 9'd1;
                        r_row_base <= w_base_nxt;
                        gen_count  <= gen_count + 16'd1;
                        r_cnt      <= '0;
                        mem_we     <= 1'b1;
                        mem_addr   <= w_base_nxt;
                        mem_data   <= w_next_gen[0];
                        busy       <= 1'b1;
                    end

                    S_WRITE: begin
                        if (r_cnt == c_last_col) begin
                            mem_we <= 1'b0;
                            busy   <= 1'b0;
                            r_cnt  <= '0;
                        end else begin
                            mem_we   <= 1'b1;
                            mem_addr <= mem_addr + ADDR_W'(1);
                            mem_data <= r_cur_gen[w_col_nxt];
                            busy     <= 1'b1;
                            r_cnt    <= r_cnt + ADDR_W'(1);
                        end
                    end

                    default: begin
                        mem_we <= 1'b0;
                        busy   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule : ca_row_generator

`default_nettype wire

// File: tb/tb_ca_row_generator.sv
// ============================================================================
//  Module      : tb_ca_row_generator
//  Description : Self-checking bench for ca_row_generator on a reduced
//                32 x 8 screen. A frame-buffer model captures every write.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ca_row_generator;

    localparam int W  = 32;
    localparam int H  = 8;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset, step, run, restart, seed_mode;
    logic [7:0]    rule;
    logic [AW-1:0] mem_addr;
    logic          mem_data, mem_we, busy;
    logic [8:0]    row;
    logic [15:0]   gen_count;

    int checks = 0;
    int errors = 0;

    logic          fb [0:1023];
    logic [AW-1:0] log_a [0:511];
    logic          log_d [0:511];
    int            log_n = 0;

    typedef struct {
        logic [7:0]  rule;
        int          n;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    ca_row_generator #(
        .WIDTH  (W),
        .HEIGHT (H),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rule      (rule),
        .seed_mode (seed_mode),
        .step      (step),
        .run       (run),
        .restart   (restart),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .busy      (busy),
        .row       (row),
        .gen_count (gen_count)
    );

    always #5 clk = ~clk;

    // Frame-buffer model: capture each write cycle once, mid-cycle
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            fb[mem_addr] = mem_data;
            if (log_n < 512) begin
                log_a[log_n] = mem_addr;
                log_d[log_n] = mem_data;
            end
            log_n = log_n + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fb_row(input int r);
        logic [31:0] v;
        for (int c = 0; c < W; c++) v[c] = fb[r * W + c];
        return v;
    endfunction

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (busy !== 1'b0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) chk({name, "_timeout"}, 64'(k), 64'(0));
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        wait_idle("restart_idle");
    endtask

    // One step pulse; returns cycles to first write and to busy low
    task automatic do_step(output int lat, output int dur);
        int k;
        lat = -1;
        dur = -1;
        k   = 0;
        @(negedge clk);
        step = 1'b1;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) step = 1'b0;
            if (lat < 0 && mem_we === 1'b1) lat = k;
            if (busy === 1'b0) begin
                dur = k;
                break;
            end
        end
        if (dur < 0) chk("step_timeout", 64'(k), 64'(0));
    endtask

    initial begin
        int          lat, dur, bad, k, r;
        logic        prev_we;
        logic [AW-1:0] prev_addr;
        logic [31:0] other, lfsr, exp_row, first_row;
        int          t[3];
        int          nt;
        logic        pw;
        logic [15:0] g0;

        tbl[0]  = '{8'd90,  1,  32'h0002_8000};
        tbl[1]  = '{8'd90,  2,  32'h0004_4000};
        tbl[2]  = '{8'd2,   1,  32'h0000_8000};
        tbl[3]  = '{8'd2,   2,  32'h0000_4000};
        tbl[4]  = '{8'd16,  1,  32'h0002_0000};
        tbl[5]  = '{8'd4,   1,  32'h0001_0000};
        tbl[6]  = '{8'd30,  1,  32'h0003_8000};
        tbl[7]  = '{8'd30,  2,  32'h0004_C000};
        tbl[8]  = '{8'd0,   1,  32'h0000_0000};
        tbl[9]  = '{8'd255, 1,  32'hFFFF_FFFF};
        tbl[10] = '{8'd2,   16, 32'h0000_0001};
        tbl[11] = '{8'd2,   17, 32'h8000_0000};

        for (int i = 0; i < 1024; i++) fb[i] = 1'b1;
        reset = 1'b1; restart = 1'b0; step = 1'b0; run = 1'b0;
        seed_mode = 1'b0; rule = 8'd90;

        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we",   64'(mem_we),    64'(0));
        chk("rst_addr", 64'(mem_addr),  64'(0));
        chk("rst_data", 64'(mem_data),  64'(0));
        chk("rst_busy", 64'(busy),      64'(1));
        chk("rst_row",  64'(row),       64'(0));
        chk("rst_gen",  64'(gen_count), 64'(0));
        log_n = 0;
        reset = 1'b0;
        @(negedge clk);
        chk("first_clear_we",   64'(mem_we),   64'(1));
        chk("first_clear_addr", 64'(mem_addr), 64'(0));

        // Track to busy fall, remembering the cycle before
        k = 0;
        prev_we = mem_we; prev_addr = mem_addr;
        while (busy !== 1'b0 && k < 2000) begin
            prev_we = mem_we; prev_addr = mem_addr;
            @(negedge clk);
            k++;
        end
        chk("busy_fall_prev", {prev_we, 54'(prev_addr)}, {1'b1, 54'(W - 1)});
        chk("idle_we", 64'(mem_we), 64'(0));
        chk("init_writes", 64'(log_n), 64'(W * H + W));
        bad = 0;
        for (int i = 0; i < W * H; i++)
            if (log_a[i] !== AW'(i) || log_d[i] !== 1'b0) bad++;
        for (int i = 0; i < W; i++)
            if (log_a[W * H + i] !== AW'(i) || log_d[W * H + i] !== (i == W / 2)) bad++;
        chk("clear_seed_order", 64'(bad), 64'(0));
        chk("seed_row0", 64'(fb_row(0)), 64'h0001_0000);
        other = '0;
        for (int rr = 1; rr < H; rr++) other |= fb_row(rr);
        chk("cleared_rows", 64'(other), 64'(0));

        // ---------------- rule 90 single step with timing ----------------
        do_step(lat, dur);
        chk("step_latency", 64'(lat), 64'(2));
        chk("step_duration", 64'(dur), 64'(W + 2));
        chk("r90_row1", 64'(fb_row(1)), 64'h0002_8000);
        chk("r90_rowout", 64'(row), 64'(1));
        chk("r90_gen", 64'(gen_count), 64'(1));

        // ---------------- table-driven generations ----------------
        for (int v = 0; v < 12; v++) begin
            rule = tbl[v].rule;
            do_restart();
            for (int s = 0; s < tbl[v].n; s++) do_step(lat, dur);
            r = tbl[v].n % H;
            chk($sformatf("tbl%0d_pattern", v), 64'(fb_row(r)), 64'(tbl[v].exp));
            chk($sformatf("tbl%0d_row", v), 64'(row), 64'(r));
            chk($sformatf("tbl%0d_gen", v), 64'(gen_count), 64'(tbl[v].n));
        end

        // ---------------- held step / pulses while busy ----------------
        rule = 8'd4;
        do_restart();
        @(negedge clk);
        step = 1'b1;
        repeat (W + 40) @(negedge clk);
        chk("held_step_gen", 64'(gen_count), 64'(1));
        step = 1'b0;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            step = ~step;
        end
        step = 1'b0;
        repeat (W + 40) @(negedge clk);
        chk("pulse_while_busy_gen", 64'(gen_count), 64'(2));
        chk("pulse_while_busy_idle", 64'(busy), 64'(0));

        // ---------------- run: back-to-back period ----------------
        nt = 0; k = 0; pw = mem_we;
        @(negedge clk);
        run = 1'b1;
        while (nt < 3 && k < 400) begin
            @(negedge clk);
            k++;
            if (mem_we === 1'b1 && pw !== 1'b1) begin
                t[nt] = k;
                nt++;
            end
            pw = mem_we;
        end
        run = 1'b0;
        chk("run_starts", 64'(nt), 64'(3));
        chk("run_period_a", 64'(t[1] - t[0]), 64'(W + 2));
        chk("run_period_b", 64'(t[2] - t[1]), 64'(W + 2));
        wait_idle("run_idle");

        // ---------------- restart mid-write ----------------
        do_restart();
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        k = 0;
        while (!(mem_we === 1'b1 && mem_addr === AW'(W + 20)) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("mid_write_reached", 64'(k < 100), 64'(1));
        g0 = gen_count;
        chk("mid_write_gen", 64'(g0), 64'(1));
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart_we",   64'(mem_we),    64'(1));
        chk("restart_addr", 64'(mem_addr),  64'(0));
        chk("restart_data", 64'(mem_data),  64'(0));
        chk("restart_gen",  64'(gen_count), 64'(0));
        chk("restart_row",  64'(row),       64'(0));
        @(negedge clk);
        chk("restart_addr1", 64'(mem_addr), 64'(1));
        wait_idle("restart_mid_idle");

        // ---------------- reset together with restart ----------------
        @(negedge clk);
        step = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1; restart = 1'b1;
        @(negedge clk);
        chk("rr_we",   64'(mem_we),    64'(0));
        chk("rr_addr", 64'(mem_addr),  64'(0));
        chk("rr_busy", 64'(busy),      64'(1));
        chk("rr_gen",  64'(gen_count), 64'(0));
        chk("rr_row",  64'(row),       64'(0));
        reset = 1'b0; restart = 1'b0; step = 1'b0;
        @(negedge clk);
        chk("rr_first_clear", {63'(mem_addr), mem_we}, {63'(0), 1'b1});
        wait_idle("rr_idle");

        // ---------------- LFSR seed, reproducible ----------------
        lfsr = 32'h0000_0001;
        for (int i = 0; i < W; i++) begin
            exp_row[i] = lfsr[0];
            lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
        end
        seed_mode = 1'b1;
        do_restart();
        first_row = fb_row(0);
        chk("lfsr_row0", 64'(first_row), 64'(exp_row));
        do_restart();
        chk("lfsr_repeat", 64'(fb_row(0)), 64'(first_row));
        chk("lfsr_repeat_model", 64'(fb_row(0)), 64'(exp_row));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ca_row_generator

`default_nettype wire
